// File: rtl/cube_match_pkg.sv
// Shared types and helpers for the cube (product-term) match monitor.
// The cube record is sized for the widest supported word; narrower instances zero-extend.
package cube_match_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_CNT_W = 16;
  localparam int unsigned MAX_WIDTH     = 64;

  // Unused upper mask bits stay 0, so they are don't-cares for any narrower word.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] value;
  } cube_t;

  function automatic logic cube_hit(input cube_t cube, input logic [MAX_WIDTH-1:0] data);
    return &(~cube.mask | ~(data ^ cube.value));
  endfunction

endpackage

// File: rtl/cube_match_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  logic [CNT_W-1:0] count_q;

  assign at_max = &count_q;
  assign count  = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && !at_max) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cube_match_monitor.sv
// Registered cube detector: one-cycle match pipeline plus saturating hit and
// hit-toggle counters for switching-activity measurement.
module cube_match_monitor
  import cube_match_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr,
  output logic             hit_valid,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] toggle_count,
  output logic             sat
);

  cube_t cube_q;
  logic  hit_valid_q;
  logic  hit_q;
  logic  match;
  logic  new_hit;
  logic  toggle_inc;
  logic  hit_at_max;
  logic  tog_at_max;

  // Compared against the cube currently held, so a same-cycle cfg_we sees the old cube.
  assign match      = cube_hit(cube_q, MAX_WIDTH'(in_data));
  assign new_hit    = in_valid & match;
  assign toggle_inc = new_hit ^ hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cube_q      <= '0;
      hit_valid_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      if (cfg_we) begin
        cube_q.mask  <= MAX_WIDTH'(cfg_mask);
        cube_q.value <= MAX_WIDTH'(cfg_value);
      end
      hit_valid_q <= in_valid;
      hit_q       <= new_hit;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (new_hit),
    .clr    (clr),
    .count  (hit_count),
    .at_max (hit_at_max)
  );

  sat_counter #(.CNT_W(CNT_W)) u_tog_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (toggle_inc),
    .clr    (clr),
    .count  (toggle_count),
    .at_max (tog_at_max)
  );

  // Counters only leave all-ones via clr/reset, which also clear sat, so a plain OR is sticky.
  assign sat       = hit_at_max | tog_at_max;
  assign hit_valid = hit_valid_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_cube_match_monitor.sv
// Randomized bench for cube_match_monitor against a behavioural model; runs a
// default-width instance and a CNT_W=2 instance side by side on shared stimulus.
module tb_cube_match_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_mask;
  logic [3:0] cfg_value;
  logic       in_valid;
  logic [3:0] in_data;
  logic       clr;

  logic        hv_b, hit_b, sat_b;
  logic [15:0] hc_b, tc_b;
  logic        hv_s, hit_s, sat_s;
  logic [1:0]  hc_s, tc_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  bit [3:0] m_mask, m_value;
  bit       m_hit, m_hv;
  int       m_hc_b, m_tc_b, m_hc_s, m_tc_s;
  bit       m_sat_b, m_sat_s;

  always #5 clk = ~clk;

  cube_match_monitor #(.WIDTH(4), .CNT_W(16)) u_dut_big (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mask(cfg_mask), .cfg_value(cfg_value),
    .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .hit_valid(hv_b), .hit(hit_b), .hit_count(hc_b), .toggle_count(tc_b), .sat(sat_b)
  );

  cube_match_monitor #(.WIDTH(4), .CNT_W(2)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mask(cfg_mask), .cfg_value(cfg_value),
    .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .hit_valid(hv_s), .hit(hit_s), .hit_count(hc_s), .toggle_count(tc_s), .sat(sat_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_match(input bit [3:0] d);
    for (int i = 0; i < 4; i++)
      if (m_mask[i] && (d[i] != m_value[i])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mask = '0; m_value = '0; m_hit = 0; m_hv = 0;
    m_hc_b = 0; m_tc_b = 0; m_hc_s = 0; m_tc_s = 0;
    m_sat_b = 0; m_sat_s = 0;
  endtask

  task automatic model_edge();
    bit nh, tg;
    nh = in_valid && model_match(in_data);
    tg = (nh != m_hit);
    if (clr) begin
      m_hc_b = 0; m_tc_b = 0; m_sat_b = 0;
      m_hc_s = 0; m_tc_s = 0; m_sat_s = 0;
    end else begin
      if (nh && m_hc_b < 65535) m_hc_b++;
      if (tg && m_tc_b < 65535) m_tc_b++;
      if (nh && m_hc_s < 3) m_hc_s++;
      if (tg && m_tc_s < 3) m_tc_s++;
      if (m_hc_b == 65535 || m_tc_b == 65535) m_sat_b = 1;
      if (m_hc_s == 3 || m_tc_s == 3) m_sat_s = 1;
    end
    m_hv  = in_valid;
    m_hit = nh;
    if (cfg_we) begin
      m_mask  = cfg_mask;
      m_value = cfg_value;
    end
  endtask

  task automatic check_all();
    check_eq("hit_valid_big", 32'(hv_b),  32'(m_hv));
    check_eq("hit_big",       32'(hit_b), 32'(m_hit));
    check_eq("hit_count_big", 32'(hc_b),  32'(m_hc_b));
    check_eq("toggle_big",    32'(tc_b),  32'(m_tc_b));
    check_eq("sat_big",       32'(sat_b), 32'(m_sat_b));
    check_eq("hit_valid_sm",  32'(hv_s),  32'(m_hv));
    check_eq("hit_sm",        32'(hit_s), 32'(m_hit));
    check_eq("hit_count_sm",  32'(hc_s),  32'(m_hc_s));
    check_eq("toggle_sm",     32'(tc_s),  32'(m_tc_s));
    check_eq("sat_sm",        32'(sat_s), 32'(m_sat_s));
  endtask

  task automatic step(input bit v, input bit [3:0] d, input bit we,
                      input bit [3:0] m, input bit [3:0] val, input bit c);
    @(negedge clk);
    in_valid = v; in_data = d; cfg_we = we; cfg_mask = m; cfg_value = val; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_hv"},  32'(hv_b | hv_s), 32'd0);
    check_eq({tag, "_hit"}, 32'(hit_b | hit_s), 32'd0);
    check_eq({tag, "_cnt"}, 32'(hc_b) + 32'(tc_b) + 32'(hc_s) + 32'(tc_s), 32'd0);
    check_eq({tag, "_sat"}, 32'(sat_b | sat_s), 32'd0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    model_reset();
    @(negedge clk);
    in_valid = 0; cfg_we = 0; clr = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 0; cfg_mask = '0; cfg_value = '0;
    in_valid = 0; in_data = '0; clr = 0;
    model_reset();
    #3;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Mask 0 after reset: every valid word matches
    for (int i = 0; i < 5; i++) begin
      step(1, 4'($urandom), 0, '0, '0, 0);
      check_eq("t1_hit", 32'(hit_b), 32'd1);
    end
    check_eq("t1_hit_count", 32'(hc_b), 32'd5);
    check_eq("t1_toggle",    32'(tc_b), 32'd1);

    // Full cube 0110 against words 6,7,6
    step(0, '0, 1, 4'b1111, 4'b0110, 1);
    step(1, 4'd6, 0, '0, '0, 0); check_eq("t2_hit6a", 32'(hit_b), 32'd1);
    step(1, 4'd7, 0, '0, '0, 0); check_eq("t2_hit7",  32'(hit_b), 32'd0);
    step(1, 4'd6, 0, '0, '0, 0); check_eq("t2_hit6b", 32'(hit_b), 32'd1);
    check_eq("t2_hit_count", 32'(hc_b), 32'd2);
    check_eq("t2_toggle",    32'(tc_b), 32'd3);

    // Reconfigure with a valid word in the same cycle: old cube applies
    step(1, 4'd6, 1, 4'b0001, 4'b0001, 0); check_eq("t3_old_cube", 32'(hit_b), 32'd1);
    step(1, 4'd6, 0, '0, '0, 0);           check_eq("t3_new_cube", 32'(hit_b), 32'd0);

    // Small counter saturation, then clr
    step(0, '0, 1, '0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 4'($urandom), 0, '0, '0, 0);
      if (i == 2) check_eq("t4_sat_3rd", 32'(sat_s), 32'd1);
    end
    check_eq("t4_hc_stick", 32'(hc_s), 32'd3);
    step(1, 4'd9, 0, '0, '0, 1);
    check_eq("t4_clr_hc",  32'(hc_s),  32'd0);
    check_eq("t4_clr_sat", 32'(sat_s), 32'd0);
    check_eq("t5_clr_hit", 32'(hit_s), 32'd1);
    check_eq("t5_clr_hcb", 32'(hc_b),  32'd0);

    // Reset between edges, then mask must be back to 0
    step(1, 4'd3, 1, 4'b1111, 4'b1010, 0);
    async_reset();
    step(1, 4'd3, 0, '0, '0, 0);
    check_eq("t6_mask_cleared", 32'(hit_b), 32'd1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 15) == 0,
             4'($urandom), 4'($urandom), $urandom_range(0, 31) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
